// File: rtl/cpu_dmem_arbiter.sv
// Single-port data RAM arbiter for pipe (stage 3a), fetch (1a) and debug host.
// Optional host aging/promotion above fetch is enabled by defining ARB_AGING_EN.
module cpu_dmem_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int HOST_MAX_WAIT = 4,
    parameter int AGE_W         = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              kill_4a,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              stall_1a,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_F    = 2'd2,
        OWN_H    = 2'd3
    } owner_t;

    owner_t owner_r;
    owner_t owner_nxt_s;
    logic   pe_s;
    logic   promote_s;
    logic   p_gnt_s;
    logic   f_gnt_s;
    logic   h_gnt_s;

    if (HOST_MAX_WAIT > (2 ** AGE_W) - 1) begin : g_age_w_check
        $error("AGE_W cannot hold HOST_MAX_WAIT");
    end

    // A killed pipe request never reaches the RAM; an earlier granted read still returns.
    assign pe_s = p_req & ~kill_4a;

`ifdef ARB_AGING_EN
    localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(HOST_MAX_WAIT);
    localparam logic [AGE_W-1:0] AGE_ONE   = AGE_W'(1);

    logic [AGE_W-1:0] age_r;
    logic [AGE_W-1:0] age_nxt_s;

    assign promote_s = (age_r >= AGE_LIMIT);

    // Count consecutive host denials, saturating; any grant or idle cycle clears.
    always_comb begin
        age_nxt_s = age_r;
        if (h_req && !h_gnt_s) begin
            if (age_r != AGE_MAX) begin
                age_nxt_s = age_r + AGE_ONE;
            end else begin
                age_nxt_s = age_r;
            end
        end else begin
            age_nxt_s = {AGE_W{1'b0}};
        end
    end

    // Host age register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            age_r <= {AGE_W{1'b0}};
        end else begin
            age_r <= age_nxt_s;
        end
    end
`else
    assign promote_s = 1'b0;
`endif

    // Fixed priority pe > fetch > host; a promoted host moves ahead of fetch only.
    always_comb begin
        p_gnt_s = 1'b0;
        f_gnt_s = 1'b0;
        h_gnt_s = 1'b0;
        if (pe_s) begin
            p_gnt_s = 1'b1;
        end else if (h_req && promote_s) begin
            h_gnt_s = 1'b1;
        end else if (f_req) begin
            f_gnt_s = 1'b1;
        end else if (h_req) begin
            h_gnt_s = 1'b1;
        end else begin
            p_gnt_s = 1'b0;
        end
    end

    // RAM port driven from the single winner in the same cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        if (p_gnt_s) begin
            ram_en    = 1'b1;
            ram_we    = p_we;
            ram_addr  = p_addr;
            ram_wdata = p_wdata;
        end else if (f_gnt_s) begin
            ram_en    = 1'b1;
            ram_we    = 1'b0;
            ram_addr  = f_addr;
            ram_wdata = {DATA_W{1'b0}};
        end else if (h_gnt_s) begin
            ram_en    = 1'b1;
            ram_we    = h_we;
            ram_addr  = h_addr;
            ram_wdata = h_wdata;
        end else begin
            ram_en    = 1'b0;
        end
    end

    // Next read owner: only granted reads return data on the following cycle.
    always_comb begin
        owner_nxt_s = OWN_NONE;
        if (p_gnt_s && !p_we) begin
            owner_nxt_s = OWN_P;
        end else if (f_gnt_s) begin
            owner_nxt_s = OWN_F;
        end else if (h_gnt_s && !h_we) begin
            owner_nxt_s = OWN_H;
        end else begin
            owner_nxt_s = OWN_NONE;
        end
    end

    // Read owner register; reset drops any outstanding read.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_nxt_s;
        end
    end

    assign p_gnt    = p_gnt_s;
    assign f_gnt    = f_gnt_s;
    assign h_gnt    = h_gnt_s;
    assign stall_1a = f_req & ~f_gnt_s;

    assign p_rvalid = (owner_r == OWN_P);
    assign f_rvalid = (owner_r == OWN_F);
    assign h_rvalid = (owner_r == OWN_H);
    assign p_rdata  = ram_rdata;
    assign f_rdata  = ram_rdata;
    assign h_rdata  = ram_rdata;

endmodule

// File: tb/tb_cpu_dmem_arbiter.sv
// Self-checking bench for cpu_dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (winner by priority, shadow memory, pending read).
module tb_cpu_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        kill_4a = 1'b0;
    logic        p_req = 1'b0, p_we = 1'b0, f_req = 1'b0, h_req = 1'b0, h_we = 1'b0;
    logic [7:0]  p_addr = 8'h00, f_addr = 8'h00, h_addr = 8'h00;
    logic [31:0] p_wdata = 32'h0, h_wdata = 32'h0;
    logic        p_gnt, p_rvalid, f_gnt, f_rvalid, h_gnt, h_rvalid, stall_1a;
    logic [31:0] p_rdata, f_rdata, h_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] ram_mem [256];
    logic        ram_load = 1'b1;
    logic [31:0] salt = 32'h0;

    int checks = 0;
    int errors = 0;

    // model state: 0 none, 1 pipe, 2 fetch, 3 host
    logic [31:0] shadow [256];
    int          e_win;
    int          pend_who = 0;
    logic [31:0] pend_data = 32'h0;
    int          age_m = 0;

    cpu_dmem_arbiter dut (
        .clk(clk), .rst_b(rst_b), .kill_4a(kill_4a),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .stall_1a(stall_1a), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    // behavioural single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    function automatic void predict();
        bit promoted;
`ifdef ARB_AGING_EN
        promoted = (age_m >= 4);
`else
        promoted = 1'b0;
`endif
        if (p_req && !kill_4a)      e_win = 1;
        else if (h_req && promoted) e_win = 3;
        else if (f_req)             e_win = 2;
        else if (h_req)             e_win = 3;
        else                        e_win = 0;
    endfunction

    function automatic void commit();
        pend_who = 0;
        if (e_win == 1) begin
            if (p_we) shadow[p_addr] = p_wdata;
            else begin pend_who = 1; pend_data = shadow[p_addr]; end
        end else if (e_win == 2) begin
            pend_who = 2; pend_data = shadow[f_addr];
        end else if (e_win == 3) begin
            if (h_we) shadow[h_addr] = h_wdata;
            else begin pend_who = 3; pend_data = shadow[h_addr]; end
        end
        if (h_req && e_win != 3) age_m = (age_m >= 7) ? 7 : age_m + 1;
        else                     age_m = 0;
    endfunction

    task automatic settle();
        @(negedge clk);
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle_inputs();
        p_req = 1'b0; p_we = 1'b0; f_req = 1'b0; h_req = 1'b0; h_we = 1'b0; kill_4a = 1'b0;
    endtask

    task automatic test_reset();
        salt = $urandom;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        rst_b = 1'b0;
        idle_inputs();
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt, ram_en, ram_we, stall_1a, p_rvalid, f_rvalid, h_rvalid} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {p_gnt, f_gnt, h_gnt, ram_en, ram_we, stall_1a, p_rvalid, f_rvalid, h_rvalid});
        end
        @(posedge clk); #1;
        ram_load = 1'b0;
        rst_b = 1'b1;
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt, ram_en, stall_1a, p_rvalid, f_rvalid, h_rvalid} !== 8'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 00000000",
                     {p_gnt, f_gnt, h_gnt, ram_en, stall_1a, p_rvalid, f_rvalid, h_rvalid});
        end
        tick();
    endtask

    task automatic test_write_priority();
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h10; p_wdata = 32'hDEADBEEF;
        f_req = 1'b1; f_addr = 8'h20;
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt, stall_1a, ram_en, ram_we} !== 6'b100111) begin
            errors++;
            $display("FAIL wr_prio_flags: got %b want 100111", {p_gnt, f_gnt, h_gnt, stall_1a, ram_en, ram_we});
        end
        checks++;
        if (ram_addr !== 8'h10 || ram_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_prio_bus: got addr %h data %h want 10 deadbeef", ram_addr, ram_wdata);
        end
        tick();
    endtask

    task automatic test_read_after_write();
        p_req = 1'b0; p_we = 1'b0;
        f_req = 1'b1; f_addr = 8'h10;
        settle();
        checks++;
        if (f_gnt !== 1'b1 || stall_1a !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL raw_gnt: got f_gnt %b stall %b we %b want 1 0 0", f_gnt, stall_1a, ram_we);
        end
        tick();
        f_req = 1'b0;
        settle();
        checks++;
        if ({p_rvalid, f_rvalid, h_rvalid} !== 3'b010 || f_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL raw_data: got rv %b data %h want 010 deadbeef", {p_rvalid, f_rvalid, h_rvalid}, f_rdata);
        end
        tick();
    endtask

    task automatic test_kill();
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h30; p_wdata = 32'h12345678; kill_4a = 1'b1;
        f_req = 1'b1; f_addr = 8'h31;
        settle();
        checks++;
        if ({p_gnt, f_gnt, ram_we, stall_1a} !== 4'b0100 || ram_addr !== 8'h31) begin
            errors++;
            $display("FAIL kill_gnt: got %b addr %h want 0100 addr 31", {p_gnt, f_gnt, ram_we, stall_1a}, ram_addr);
        end
        tick();
        kill_4a = 1'b0; p_we = 1'b0; p_addr = 8'h32; f_req = 1'b0;
        settle();
        checks++;
        if (p_gnt !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== pend_data) begin
            errors++;
            $display("FAIL kill_fetch_rd: got gnt %b rv %b data %h want 1 1 %h", p_gnt, f_rvalid, f_rdata, pend_data);
        end
        tick();
        kill_4a = 1'b1;
        settle();
        checks++;
        if (p_gnt !== 1'b0 || ram_en !== 1'b0 || p_rvalid !== 1'b1 || p_rdata !== pend_data) begin
            errors++;
            $display("FAIL kill_late_rvalid: got gnt %b en %b rv %b data %h want 0 0 1 %h",
                     p_gnt, ram_en, p_rvalid, p_rdata, pend_data);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_aging();
        bit exp_h;
        f_req = 1'b1; f_addr = 8'h40; h_req = 1'b1; h_we = 1'b0; h_addr = 8'h41;
        for (int cyc = 1; cyc <= 8; cyc++) begin
`ifdef ARB_AGING_EN
            exp_h = (cyc == 5);
`else
            exp_h = 1'b0;
`endif
            settle();
            checks++;
            if (h_gnt !== exp_h || f_gnt !== !exp_h || stall_1a !== exp_h) begin
                errors++;
                $display("FAIL aging_c%0d: got h %b f %b stall %b want %b %b %b",
                         cyc, h_gnt, f_gnt, stall_1a, exp_h, !exp_h, exp_h);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_three_way();
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h50;
        f_req = 1'b1; f_addr = 8'h51;
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'h52;
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL three_c1: got %b want 100", {p_gnt, f_gnt, h_gnt});
        end
        tick();
        p_req = 1'b0;
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt} !== 3'b010 || p_rvalid !== 1'b1 || p_rdata !== shadow[8'h50]) begin
            errors++;
            $display("FAIL three_c2: got gnt %b rv %b data %h want 010 1 %h",
                     {p_gnt, f_gnt, h_gnt}, p_rvalid, p_rdata, shadow[8'h50]);
        end
        tick();
        f_req = 1'b0;
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt} !== 3'b001 || f_rvalid !== 1'b1 || f_rdata !== shadow[8'h51]) begin
            errors++;
            $display("FAIL three_c3: got gnt %b rv %b data %h want 001 1 %h",
                     {p_gnt, f_gnt, h_gnt}, f_rvalid, f_rdata, shadow[8'h51]);
        end
        tick();
        h_req = 1'b0;
        settle();
        checks++;
        if ({p_rvalid, f_rvalid, h_rvalid} !== 3'b001 || h_rdata !== shadow[8'h52]) begin
            errors++;
            $display("FAIL three_c4: got rv %b data %h want 001 %h", {p_rvalid, f_rvalid, h_rvalid}, h_rdata, shadow[8'h52]);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        f_req = 1'b1; f_addr = 8'h60;
        settle();
        checks++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b want 1", f_gnt);
        end
        tick();
        rst_b = 1'b0;
        idle_inputs();
        pend_who = 0; age_m = 0;
        settle();
        checks++;
        if ({p_gnt, f_gnt, h_gnt, ram_en, ram_we, stall_1a, p_rvalid, f_rvalid, h_rvalid} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b want 000000000",
                     {p_gnt, f_gnt, h_gnt, ram_en, ram_we, stall_1a, p_rvalid, f_rvalid, h_rvalid});
        end
        tick();
        rst_b = 1'b1;
        f_req = 1'b1;
        settle();
        checks++;
        if (f_gnt !== 1'b1 || f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_regnt: got gnt %b rv %b want 1 0", f_gnt, f_rvalid);
        end
        tick();
        f_req = 1'b0;
        settle();
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== shadow[8'h60]) begin
            errors++;
            $display("FAIL rstmid_rdata: got rv %b data %h want 1 %h", f_rvalid, f_rdata, shadow[8'h60]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [2:0]  exp_g;
        logic [2:0]  exp_rv;
        logic [31:0] act_rd;
        for (int n = 0; n < 400; n++) begin
            if (!p_req && $urandom_range(0, 99) < 40) begin
                p_req = 1'b1; p_we = 1'($urandom_range(0, 1)); p_addr = 8'($urandom_range(0, 7));
                p_wdata = $urandom;
            end
            if (!f_req && $urandom_range(0, 99) < 40) begin
                f_req = 1'b1; f_addr = 8'($urandom_range(0, 7));
            end
            if (!h_req && $urandom_range(0, 99) < 30) begin
                h_req = 1'b1; h_we = 1'($urandom_range(0, 1)); h_addr = 8'($urandom_range(0, 7));
                h_wdata = $urandom;
            end
            kill_4a = ($urandom_range(0, 99) < 20);
            settle();
            exp_g  = {e_win == 1, e_win == 2, e_win == 3};
            exp_rv = {pend_who == 1, pend_who == 2, pend_who == 3};
            checks++;
            if ({p_gnt, f_gnt, h_gnt} !== exp_g || ram_en !== (e_win != 0) || stall_1a !== (f_req && e_win != 2)) begin
                errors++;
                $display("FAIL rnd_gnt n=%0d: got gnt %b en %b stall %b want %b %b %b",
                         n, {p_gnt, f_gnt, h_gnt}, ram_en, stall_1a, exp_g, e_win != 0, f_req && e_win != 2);
            end
            if (e_win != 0) begin
                logic        ew;
                logic [7:0]  ea;
                logic [31:0] ed;
                ew = (e_win == 1) ? p_we : (e_win == 3) ? h_we : 1'b0;
                ea = (e_win == 1) ? p_addr : (e_win == 2) ? f_addr : h_addr;
                ed = (e_win == 1) ? p_wdata : h_wdata;
                checks++;
                if (ram_we !== ew || ram_addr !== ea || (ew && ram_wdata !== ed)) begin
                    errors++;
                    $display("FAIL rnd_bus n=%0d: got we %b addr %h data %h want %b %h %h",
                             n, ram_we, ram_addr, ram_wdata, ew, ea, ed);
                end
            end
            act_rd = (pend_who == 1) ? p_rdata : (pend_who == 2) ? f_rdata : h_rdata;
            checks++;
            if ({p_rvalid, f_rvalid, h_rvalid} !== exp_rv || (pend_who != 0 && act_rd !== pend_data)) begin
                errors++;
                $display("FAIL rnd_read n=%0d: got rv %b data %h want %b %h",
                         n, {p_rvalid, f_rvalid, h_rvalid}, act_rd, exp_rv, pend_data);
            end
            tick();
            if (e_win == 1) p_req = 1'b0;
            if (e_win == 2) f_req = 1'b0;
            if (e_win == 3) h_req = 1'b0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_priority();
        test_read_after_write();
        test_kill();
        test_aging();
        test_three_way();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
